// File: rtl/src_flow_ctrl_if.sv
// Handshake/data bundle between the source flow controller, its producers, buffer and UI.
// The slave modport is the controller's view; master is the surrounding system's view.
interface src_flow_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 16
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        start;
  logic                      stop;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      buf_full;
  logic                      buf_empty;
  logic                      rd_valid;
  logic [NUM_SRC-1:0]        src_en;
  logic                      buf_wr;
  logic [DATA_W-1:0]         buf_data;
  logic [SEL_W-1:0]          sel;
  logic                      active;
  logic                      timeout;
  logic [3:0]                led;

  modport slave (
    input  start, stop, src_valid, src_data, buf_full, buf_empty, rd_valid,
    output src_en, buf_wr, buf_data, sel, active, timeout, led
  );

  modport master (
    output start, stop, src_valid, src_data, buf_full, buf_empty, rd_valid,
    input  src_en, buf_wr, buf_data, sel, active, timeout, led
  );
endinterface

// File: rtl/src_flow_ctrl.sv
// N-channel producer arbiter into one buffer, sequencing IDLE/COMM/WAIT/DRAIN; zero-latency write path.
// Optional WAIT timeout (forced drain + sticky flag) under macro SRC_FLOW_CTRL_WAIT_TIMEOUT_EN.
module src_flow_ctrl #(
  parameter int NUM_SRC      = 2,
  parameter int DATA_W       = 16,
  parameter int WAIT_TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  src_flow_ctrl_if.slave bus
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMM, S_WAIT, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [NUM_SRC-1:0] r_start_q;
  logic               r_stop_q;
  logic [NUM_SRC-1:0] w_start_rise;
  logic [NUM_SRC-1:0] w_other_rise;
  logic [NUM_SRC-1:0] w_sel_oh;
  logic               w_stop_rise;
  logic               w_wait_expired;
  logic               w_comm_open;
  logic [NUM_SRC-1:0] w_src_en;
  logic [DATA_W-1:0]  w_slice;
  logic               w_buf_wr;

  function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_SRC-1:0] v);
    f_lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SEL_W'(i);
    end
  endfunction

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_stop_rise  = bus.stop & ~r_stop_q;
  assign w_other_rise = w_start_rise & ~w_sel_oh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_start_q <= '0;
      r_stop_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_start_q <= bus.start;
      r_stop_q  <= bus.stop;
    end
  end

  // Stop outranks everything; a rise on the already-selected channel is not a switch request.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      S_IDLE: begin
        if (|w_start_rise) begin
          w_state_nxt = S_COMM;
          w_sel_nxt   = f_lowest(w_start_rise);
        end
      end
      S_COMM: begin
        if (w_stop_rise)          w_state_nxt = S_DRAIN;
        else if (bus.buf_full)    w_state_nxt = S_WAIT;
        else if (|w_other_rise)   w_sel_nxt   = f_lowest(w_other_rise);
      end
      S_WAIT: begin
        if (w_stop_rise)          w_state_nxt = S_DRAIN;
        else if (!bus.buf_full)   w_state_nxt = S_COMM;
        else if (w_wait_expired)  w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.buf_empty && !bus.rd_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SRC_FLOW_CTRL_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_tmo_set;

  assign w_wait_expired = (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
  assign w_tmo_set      = (r_state == S_WAIT) && !w_stop_rise && bus.buf_full && w_wait_expired;

  // Counts WAIT cycles; any other state holds it at zero so each WAIT entry starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
      if (w_tmo_set)
        r_timeout <= 1'b1;
      else if (r_state == S_IDLE && w_state_nxt == S_COMM)
        r_timeout <= 1'b0;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_wait_expired = 1'b0;
  assign bus.timeout    = (WAIT_TIMEOUT < 0);
`endif

  assign w_comm_open = (r_state == S_COMM) && !bus.buf_full;

  always_comb begin
    w_sel_oh = '0;
    w_src_en = '0;
    w_slice  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_src_en[i] = w_comm_open;
        w_slice     = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_buf_wr     = |(w_src_en & bus.src_valid);
  assign bus.src_en   = w_src_en;
  assign bus.buf_wr   = w_buf_wr;
  assign bus.buf_data = w_buf_wr ? w_slice : '0;
  assign bus.sel      = r_sel;
  assign bus.active   = (r_state != S_IDLE);

  always_comb begin
    case (r_state)
      S_IDLE:  bus.led = 4'b0001;
      S_COMM:  bus.led = 4'b0010;
      S_WAIT:  bus.led = 4'b0100;
      S_DRAIN: bus.led = 4'b1000;
      default: bus.led = 4'b0000;
    endcase
  end
endmodule
